// File: rtl/xor_frame_checksum_pkg.sv
// Shared types and helpers for the streaming XOR frame checksum unit.
// Contents: frame FSM state enum, count-width helper function.
// No ports (package only).
package xor_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } xor_chk_state_t;

  // Bits needed to hold values 0..max inclusive.
  function automatic int count_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/xor_frame_checksum_lane_reduce.sv
// xor_lane_reduce: combinational XOR fold of LANES words into one WIDTH-bit word.
// Ports: in_data (LANES*WIDTH, lane k = bits [k*WIDTH +: WIDTH]) -> out_word (WIDTH).
// Latency: zero (pure combinational); no handshake, no backpressure.
module xor_lane_reduce #(
  parameter int WIDTH = 8,
  parameter int LANES = 2
) (
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]       out_word
);

  always_comb begin
    out_word = '0;
    for (int k = 0; k < LANES; k++) begin
      out_word = out_word ^ in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum: XOR-folds every word of a frame into a WIDTH-bit checksum.
// Latency: out_valid rises the cycle after the in_last beat is accepted.
// Backpressure: result held (in_ready=0) until out_ready; in_ready is registered.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_data/in_last input
//        handshake; out_valid/out_ready/out_chk/out_beats/out_ovf result handshake;
//        out_parity only when XOR_CHK_PARITY_EN is defined.
module xor_frame_checksum
  import xor_chk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 2,
  parameter int MAX_BEATS = 16,
  localparam int CW       = count_width(MAX_BEATS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_chk,
  output logic [CW-1:0]          out_beats,
`ifdef XOR_CHK_PARITY_EN
  output logic                   out_parity,
`endif
  output logic                   out_ovf
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  xor_chk_state_t   state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] beat_val;
  logic             in_acc;
`ifdef XOR_CHK_PARITY_EN
  logic             parity_q, parity_d;
`endif

  xor_lane_reduce #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_reduce (
    .in_data  (in_data),
    .out_word (beat_val)
  );

  assign in_acc = in_valid && in_ready_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
`ifdef XOR_CHK_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (in_acc) begin
          acc_d = acc_q ^ beat_val;
          // Count saturates; a beat beyond the limit only marks overflow.
          if (count_q == MAX_CNT) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
          state_d = in_last ? HOLD : ACCUM;
`ifdef XOR_CHK_PARITY_EN
          parity_d = ^acc_d;
`endif
        end
      end
      HOLD: begin
        // Acc/count stay frozen in HOLD, so they double as the result registers.
        if (out_ready) begin
          state_d  = IDLE;
          acc_d    = '0;
          count_d  = '0;
          ovf_d    = 1'b0;
`ifdef XOR_CHK_PARITY_EN
          parity_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake outputs are decoded from the next state and registered.
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef XOR_CHK_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef XOR_CHK_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_chk    = acc_q;
  assign out_beats  = count_q;
  assign out_ovf    = ovf_q;
`ifdef XOR_CHK_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule
